// File: rtl/sd_sector_mover.sv
// Moves one sector of WORDS 32-bit words between a byte-addressed sdcram port
// and a valid/ready read or write stream.
`timescale 1ns/1ps
module sd_sector_mover #(
  parameter int WORDS  = 128,
  parameter int ADDR_W = 41
) (
  input  logic              w_CLK,
  input  logic              w_i_rst_n,
  input  logic              w_i_start,
  input  logic              w_i_write,
  input  logic [31:0]       w_i_sector,
  output logic              w_o_busy,
  output logic              w_o_done,
  output logic [31:0]       w_o_rd_data,
  output logic              w_o_rd_valid,
  input  logic              w_i_rd_ready,
  input  logic [31:0]       w_i_wr_data,
  input  logic              w_i_wr_valid,
  output logic              w_o_wr_ready,
  output logic [ADDR_W-1:0] w_o_sdcram_addr,
  output logic              w_o_sdcram_ren,
  output logic [3:0]        w_o_sdcram_wen,
  output logic [31:0]       w_o_sdcram_wdata,
  input  logic [31:0]       w_i_sdcram_rdata,
  input  logic              w_i_sdcram_busy
);

  localparam int KW = $clog2(WORDS);
  localparam int FW = 32 + KW + 2;
  localparam int EW = (FW > ADDR_W) ? FW : ADDR_W;

  // Stream handshakes: a word moves on a cycle where valid and ready are both 1;
  // the sender keeps valid and data stable until that cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_WR_IN, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  state_t            r_state;
  logic [31:0]       r_sector;
  logic [KW-1:0]     r_k;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rd_data;
  logic [31:0]       r_wdata;
  logic              w_last;

  // WORDS is a power of two, so sector*WORDS + k is a plain concatenation.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [31:0] sec, input logic [KW-1:0] k);
    logic [EW-1:0] wide;
    wide = EW'({sec, k, 2'b00});
    return wide[ADDR_W-1:0];
  endfunction

  assign w_last = (r_k == KW'(WORDS - 1));

  always_ff @(posedge w_CLK or negedge w_i_rst_n) begin
    if (!w_i_rst_n) begin
      r_state   <= S_IDLE;
      r_sector  <= '0;
      r_k       <= '0;
      r_addr    <= '0;
      r_rd_data <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_i_start) begin
            r_sector <= w_i_sector;
            r_k      <= '0;
            r_addr   <= f_addr(w_i_sector, '0);
            r_state  <= w_i_write ? S_WR_IN : S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!w_i_sdcram_busy) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (!w_i_sdcram_busy) begin
            r_rd_data <= w_i_sdcram_rdata;
            r_state   <= S_RD_OUT;
          end
        end
        S_RD_OUT: begin
          if (w_i_rd_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + KW'(1);
              r_addr  <= f_addr(r_sector, r_k + KW'(1));
              r_state <= S_RD_REQ;
            end
          end
        end
        S_WR_IN: begin
          if (w_i_wr_valid) begin
            r_wdata <= w_i_wr_data;
            r_state <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!w_i_sdcram_busy) r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (!w_i_sdcram_busy) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + KW'(1);
              r_addr  <= f_addr(r_sector, r_k + KW'(1));
              r_state <= S_WR_IN;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by sdcram busy in the request cycle so each fires exactly once.
  assign w_o_sdcram_ren   = (r_state == S_RD_REQ) && !w_i_sdcram_busy;
  assign w_o_sdcram_wen   = {4{(r_state == S_WR_REQ) && !w_i_sdcram_busy}};
  assign w_o_sdcram_addr  = r_addr;
  assign w_o_sdcram_wdata = r_wdata;
  assign w_o_rd_data      = r_rd_data;
  assign w_o_rd_valid     = (r_state == S_RD_OUT);
  assign w_o_wr_ready     = (r_state == S_WR_IN);
  assign w_o_busy         = (r_state != S_IDLE);
  assign w_o_done         = (r_state == S_DONE);

endmodule
